alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
Front end of the RV32I execute path. It accepts a fetched instruction with its register-file operands, decodes opcode/funct3/funct7 into the 4-bit ALU operation code, and drives the ALU's a/b/alu_control inputs from an issue register. It captures the ALU's result/zero return into a writeback register, including branch resolution. Both stages use a valid/ready handshake, so the block sits between decode/regfile read and writeback/branch redirect.

Parameters:
XLEN, 32, datapath width; fixed at 32 for RV32I.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream instruction valid
in_ready  output  1  block can accept the instruction this cycle
in_instr  input  32  raw RV32I instruction
in_pc  input  32  instruction PC
in_rs1_data  input  32  rs1 value
in_rs2_data  input  32  rs2 value
alu_a  output  32  ALU operand a
alu_b  output  32  ALU operand b
alu_control  output  4  ALU op code
alu_result  input  32  ALU result (combinational from alu_a/alu_b/alu_control)
alu_zero  input  1  ALU zero flag
wb_valid  output  1  writeback entry valid
wb_ready  input  1  downstream accepts the writeback entry
wb_rd  output  5  destination register
wb_data  output  32  captured ALU result
wb_we  output  1  register write enable
br_taken  output  1  resolved branch taken
br_target  output  32  branch target
illegal  output  1  instruction not supported by this stage

Behaviour:
- ALU op codes: AND=0000, OR=0001, ADD=0010, SUB=0110, SLTU=0111 (the ALU compares unsigned). NOR=1100 is never issued.
- Decode, registered into the issue stage (S1) on acceptance:
  - R-type (0110011):
    - f3=000 with f7[5]=0 -> ADD; with f7[5]=1 -> SUB.
    - f3=111 -> AND; 110 -> OR; 011 -> SLTU.
    - Any other f3/f7 -> illegal.
  - I-ALU (0010011): addi/andi/ori/sltiu map to ADD/AND/OR/SLTU with b = sext(instr[31:20]); other f3 -> illegal.
  - Load (0000011): ADD, b = sext(I-imm). Store (0100011): ADD, b = sext(S-imm). wb_we=0 for both.
  - Branch (1100011): f3=000 (beq) and 001 (bne) -> SUB, b = rs2; other f3 -> illegal.
  - All other opcodes (incl. signed SLT/SLTI, XOR, shifts, LUI/AUIPC/JAL/JALR) -> illegal.
  - For illegal entries: alu_control=0000, wb_we=0, br_taken=0.
  - a = rs1 for all supported ops.
- alu_a, alu_b and alu_control come directly from S1 registers (no combinational path from in_*).
- Handshake:
  - s1_adv = s1_valid & (~wb_valid | wb_ready).
  - in_ready = ~s1_valid | s1_adv; forced 0 while reset is high.
  - Transfer occurs when in_valid & in_ready. Upstream must hold in_* stable while in_valid & ~in_ready.
- On s1_adv, the writeback register (S2) loads:
  - wb_data = alu_result.
  - wb_rd = instr[11:7], or 0 for store/branch.
  - wb_we = 1 for R-type/I-ALU with rd != 0, else 0.
  - br_taken = beq ? alu_zero : bne ? ~alu_zero : 0.
  - br_target = pc + sext(B-imm), modulo 2^32.
  - illegal copies the decoded flag.
- S2 entry held stable while wb_valid & ~wb_ready. wb_valid clears when the entry is taken and S1 is empty.
- Simultaneous accept into S1 and S1->S2 advance in the same cycle is required; throughput is 1 instr/cycle with wb_ready=1.
- Latency: instruction accepted at edge N -> wb_valid high after edge N+1.
- Reset:
  - All valids, S1 and S2 registers are cleared to 0: alu_a=alu_b=0, alu_control=0000, wb_*=0, br_taken=0, br_target=0, illegal=0.
  - Reset mid-operation discards in-flight entries with no wb_valid pulse.
  - in_ready goes to 1 on the first cycle after reset deasserts.
- Ordering is strictly in-order; no entry is dropped or duplicated under any backpressure pattern.

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, wb_ready=1 -> alu_control=0010 during S1; next cycle wb_valid=1, wb_rd=3, wb_data=12, wb_we=1.
- sub x3,x1,x2 (0x402081B3), rs1=5, rs2=7 -> alu_control=0110, wb_data=0xFFFFFFFE, wb_we=1.
- beq x1,x2,+8 (0x00208463), pc=0x100, rs1=rs2=9 -> br_taken=1, br_target=0x108, wb_we=0. Same with rs2=8 -> br_taken=0.
- Backpressure: wb_ready=0, stream of 3 addi instrs -> in_ready drops after 2 accepted, wb_* stable. Release wb_ready -> 3 entries emerge in order with correct results and no duplicates.
- Unsupported ops: xor x3,x1,x2 (0x0020C1B3) -> illegal=1, wb_we=0, alu_control=0000. addi x0,x0,5 (0x00500013) -> wb_data=5, wb_we=0.
- Reset asserted one cycle after accepting an add with wb_ready=0 -> no wb_valid pulse. All outputs 0 during reset; in_ready=1 on the first cycle after reset deasserts.

Source files
------------

// File: rtl/alu_issue_stage.sv
// RV32I issue stage: decodes into registered ALU inputs (S1), captures the ALU return into a writeback register (S2).
// Latency 1 cycle accept->wb_valid; S2 holds under wb_ready=0 and S1 stalls behind it, dropping in_ready.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_control,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_we,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  output logic            illegal
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b;
  logic            unused_rs1_field;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign rd     = in_instr[11:7];
  assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  // Register indices are resolved upstream; only the operand values arrive here.
  assign unused_rs1_field = ^in_instr[19:15];

  logic [3:0]      dec_ctrl;
  logic [XLEN-1:0] dec_b;
  logic [4:0]      dec_rd;
  logic            dec_we, dec_beq, dec_bne, dec_illegal;

  always_comb begin
    dec_ctrl    = OP_AND;
    dec_b       = in_rs2_data;
    dec_rd      = rd;
    dec_we      = 1'b0;
    dec_beq     = 1'b0;
    dec_bne     = 1'b0;
    dec_illegal = 1'b1;
    case (opcode)
      OPC_R: begin
        dec_we = 1'b1;
        if (f7 == 7'b0100000 && f3 == 3'b000) begin
          dec_ctrl    = OP_SUB;
          dec_illegal = 1'b0;
        end else if (f7 == 7'b0000000) begin
          dec_illegal = 1'b0;
          case (f3)
            3'b000:  dec_ctrl = OP_ADD;
            3'b111:  dec_ctrl = OP_AND;
            3'b110:  dec_ctrl = OP_OR;
            3'b011:  dec_ctrl = OP_SLTU;
            default: dec_illegal = 1'b1;
          endcase
        end
      end
      OPC_I: begin
        dec_we      = 1'b1;
        dec_b       = imm_i;
        dec_illegal = 1'b0;
        case (f3)
          3'b000:  dec_ctrl = OP_ADD;
          3'b111:  dec_ctrl = OP_AND;
          3'b110:  dec_ctrl = OP_OR;
          3'b011:  dec_ctrl = OP_SLTU;
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_ctrl    = OP_ADD;
        dec_b       = imm_i;
        dec_illegal = 1'b0;
      end
      OPC_STORE: begin
        dec_ctrl    = OP_ADD;
        dec_b       = imm_s;
        dec_rd      = 5'd0;
        dec_illegal = 1'b0;
      end
      OPC_BR: begin
        dec_ctrl    = OP_SUB;
        dec_rd      = 5'd0;
        dec_beq     = (f3 == 3'b000);
        dec_bne     = (f3 == 3'b001);
        dec_illegal = ~(dec_beq | dec_bne);
      end
      default: ;
    endcase
    // Illegal entries still flow through so downstream can trap in order.
    if (dec_illegal) begin
      dec_ctrl = OP_AND;
      dec_we   = 1'b0;
      dec_beq  = 1'b0;
      dec_bne  = 1'b0;
    end
    dec_we = dec_we & (rd != 5'd0);
  end

  logic            s1_valid, s1_we, s1_beq, s1_bne, s1_illegal;
  logic [4:0]      s1_rd;
  logic [XLEN-1:0] s1_target;
  logic            s1_adv, accept;

  assign s1_adv   = s1_valid & (~wb_valid | wb_ready);
  assign in_ready = ~reset & (~s1_valid | s1_adv);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= OP_AND;
      s1_rd       <= 5'd0;
      s1_we       <= 1'b0;
      s1_beq      <= 1'b0;
      s1_bne      <= 1'b0;
      s1_illegal  <= 1'b0;
      s1_target   <= '0;
    end else if (accept) begin
      s1_valid    <= 1'b1;
      alu_a       <= in_rs1_data;
      alu_b       <= dec_b;
      alu_control <= dec_ctrl;
      s1_rd       <= dec_rd;
      s1_we       <= dec_we;
      s1_beq      <= dec_beq;
      s1_bne      <= dec_bne;
      s1_illegal  <= dec_illegal;
      s1_target   <= in_pc + imm_b;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid  <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= '0;
      wb_we     <= 1'b0;
      br_taken  <= 1'b0;
      br_target <= '0;
      illegal   <= 1'b0;
    end else if (s1_adv) begin
      wb_valid  <= 1'b1;
      wb_rd     <= s1_rd;
      wb_data   <= alu_result;
      wb_we     <= s1_we;
      br_taken  <= (s1_beq & alu_zero) | (s1_bne & ~alu_zero);
      br_target <= s1_target;
      illegal   <= s1_illegal;
    end else if (wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

endmodule
